// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin arbiter granting four channels a turn-on/drive/turn-off window on the uio bus.
// Define CLEAR_ON_READ_EN to clear the granted channel's counter once its bus window closes.
module uio_bus_arbiter #(
  parameter int HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  typedef enum logic [1:0] {IDLE, TURN_ON, DRIVE, TURN_OFF} state_t;
  state_t r_state, w_next;
  logic [3:0] r_grant, r_hold, w_req, w_inc;
  logic [1:0] r_idx, r_last, w_win;
  logic [7:0] r_cnt [4];
  logic w_any, w_drive, w_unused;
  assign w_req = ui_in[3:0];
  assign w_inc = ui_in[7:4];
  assign w_unused = &{1'b0, ena, uio_in};
  // Descending scan so the nearest channel after r_last is assigned last and wins.
  always_comb begin
    w_win = r_last;
    w_any = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (w_req[r_last + 2'(k)]) begin
        w_win = r_last + 2'(k);
        w_any = 1'b1;
      end
    end
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_any ? TURN_ON : IDLE;
      TURN_ON: w_next = DRIVE;
      DRIVE:   w_next = (!w_req[r_idx] || r_hold == 4'(HOLD - 1)) ? TURN_OFF : DRIVE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= 4'b0000;
      r_idx   <= 2'd0;
      r_last  <= 2'd3;
      r_hold  <= 4'd0;
    end else begin
      r_state <= w_next;
      r_hold  <= (r_state == DRIVE) ? r_hold + 4'd1 : 4'd0;
      if (r_state == IDLE && w_any) begin
        r_grant <= 4'b0001 << w_win;
        r_idx   <= w_win;
        r_last  <= w_win;
      end
      if (r_state == TURN_OFF) begin
        r_grant <= 4'b0000;
        r_idx   <= 2'd0;
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n)
        r_cnt[i] <= 8'h00;
`ifdef CLEAR_ON_READ_EN
      else if (r_state == TURN_OFF && r_idx == 2'(i))
        r_cnt[i] <= 8'h00;
`endif
      else if (w_inc[i])
        r_cnt[i] <= r_cnt[i] + 8'd1;
    end
  end
  assign w_drive = (r_state == DRIVE);
  assign uo_out  = {w_drive, r_state != IDLE, r_idx, r_grant};
  assign uio_out = w_drive ? r_cnt[r_idx] : 8'h00;
  assign uio_oe  = {8{w_drive}};
endmodule

// File: tb/tb_uio_bus_arbiter.sv
// tb_uio_bus_arbiter: directed scoreboard bench for uio_bus_arbiter (HOLD=4).
module tb_uio_bus_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic [7:0] ui_in = 8'h00, uio_in = 8'hA5;
  logic [7:0] uo_out, uio_out, uio_oe;
  typedef struct {string tag; logic [23:0] v;} item_t;
  item_t q[$];
  int pass_cnt = 0, fail_cnt = 0, total = 0;
  uio_bus_arbiter #(.HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
    .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  always #5 clk = ~clk;
  // ph: 0 idle, 1 turn-on, 2 drive, 3 turn-off
  function automatic logic [7:0] exp_uo(input int ph, input int ch);
    logic [3:0] g;
    g = 4'b0001 << ch;
    return ph == 0 ? 8'h00 : {ph == 2, 1'b1, 2'(ch), g};
  endfunction
  task automatic expect_ph(input string tag, input int ph, input int ch, input logic [7:0] cnt);
    item_t it;
    it.tag = tag;
    it.v = {exp_uo(ph, ch), ph == 2 ? cnt : 8'h00, ph == 2 ? 8'hFF : 8'h00};
    q.push_back(it);
  endtask
  task automatic tick;
    item_t it;
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      it = q.pop_front();
      total++;
      assert ({uo_out, uio_out, uio_oe} === it.v) pass_cnt++;
      else begin
        fail_cnt++;
        $error("FAIL %s: got uo/uio/oe=%h want %h", it.tag, {uo_out, uio_out, uio_oe}, it.v);
      end
    end
  endtask
  initial begin
    logic [7:0] second;
    ui_in = 8'hF0;
    repeat (2) begin expect_ph("reset", 0, 0, 0); tick(); end
    rst_n = 1'b1;
    ui_in = 8'h01;
    expect_ph("first_on", 1, 0, 0); tick();
    repeat (4) begin expect_ph("first_drive", 2, 0, 0); tick(); end
    expect_ph("first_off", 3, 0, 0); tick();
    ui_in = 8'h00;
    expect_ph("first_idle", 0, 0, 0); tick();
    rst_n = 1'b0;
    expect_ph("rr_reset", 0, 0, 0); tick();
    rst_n = 1'b1;
    ui_in = 8'h0F;
    for (int c = 0; c < 3; c++) begin
      expect_ph("rr_on", 1, c, 0); tick();
      repeat (4) begin expect_ph("rr_drive", 2, c, 0); tick(); end
      expect_ph("rr_off", 3, c, 0); tick();
      if (c == 2) ui_in = 8'h00;
      expect_ph("rr_idle", 0, 0, 0); tick();
    end
    ui_in = 8'h40;
    repeat (300) @(posedge clk);
    #1;
    ui_in = 8'h04;
    expect_ph("wrap_on", 1, 2, 0); tick();
    repeat (4) begin expect_ph("wrap_drive", 2, 2, 8'd44); tick(); end
    expect_ph("wrap_off", 3, 2, 0); tick();
    ui_in = 8'h00;
    expect_ph("wrap_idle", 0, 0, 0); tick();
    ui_in = 8'h02;
    expect_ph("early_on", 1, 1, 0); tick();
    expect_ph("early_drive1", 2, 1, 0); tick();
    ui_in = 8'h8B;
    expect_ph("early_drive2", 2, 1, 0); tick();
    ui_in = 8'h89;
    expect_ph("early_off", 3, 1, 0); tick();
    expect_ph("early_idle", 0, 0, 0); tick();
    expect_ph("ch3_on", 1, 3, 0); tick();
    expect_ph("ch3_drive", 2, 3, 8'd5); tick();
    rst_n = 1'b0;
    expect_ph("mid_drive_reset", 0, 0, 0); tick();
    rst_n = 1'b1;
    ui_in = 8'h08;
    expect_ph("post_rst_on", 1, 3, 0); tick();
    expect_ph("post_rst_drive", 2, 3, 0); tick();
    ui_in = 8'h88;
    for (int n = 1; n <= 3; n++) begin expect_ph("live_track", 2, 3, 8'(n)); tick(); end
    ui_in = 8'h00;
    expect_ph("post_rst_off", 3, 3, 0); tick();
    expect_ph("post_rst_idle", 0, 0, 0); tick();
    ui_in = 8'h10;
    repeat (10) @(posedge clk);
    #1;
    ui_in = 8'h01;
    expect_ph("read1_on", 1, 0, 0); tick();
    repeat (4) begin expect_ph("read1_drive", 2, 0, 8'd10); tick(); end
    expect_ph("read1_off", 3, 0, 0); tick();
    ui_in = 8'h00;
    expect_ph("read1_idle", 0, 0, 0); tick();
`ifdef CLEAR_ON_READ_EN
    second = 8'h00;
`else
    second = 8'd10;
`endif
    ui_in = 8'h01;
    expect_ph("read2_on", 1, 0, 0); tick();
    repeat (4) begin expect_ph("read2_drive", 2, 0, second); tick(); end
    expect_ph("read2_off", 3, 0, 0); tick();
    ui_in = 8'h00;
    expect_ph("read2_idle", 0, 0, 0); tick();
    total++;
    assert (q.size() == 0) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
